// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the access-size helper.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    // Access size in bytes; the 11 encoding is rejected elsewhere.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the LSU (master) and the
// data-memory responder (slave).
interface dmem_responder_if;

    logic        i_req;
    logic        o_ready;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_rvalid;
    logic [31:0] o_ld_data;
    logic        o_err;

    modport master (
        output i_req, i_wren, i_funct3, i_addr, i_st_data,
        input  o_ready, o_rvalid, o_ld_data, o_err
    );

    modport slave (
        input  i_req, i_wren, i_funct3, i_addr, i_st_data,
        output o_ready, o_rvalid, o_ld_data, o_err
    );

endinterface

// File: rtl/dmem_bytelane_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered
// (one-cycle) read port. Contents are not reset.
module dmem_bytelane_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// RV32I load/store responder: one access at a time, misaligned accesses that
// straddle a word boundary are split into two sequential RAM cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic         i_clk,
    input  logic         i_reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t state, state_nx;

    logic          ready, rvalid, accept;
    logic          acc_err, acc_span;
    logic [2:0]    acc_size;
    logic [3:0]    acc_end;

    logic          wren_q, span_q, err_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] w0_q;
    logic [31:0]   st_q, word0_q, ld_q;

    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata, ram_rdata;

    logic [3:0]    size_mask;
    logic [7:0]    be;
    logic [63:0]   wvec, rd_src;
    logic [31:0]   pair, ld_ext;

    assign accept   = bus.i_req & ready;
    assign acc_size = size_of(bus.i_funct3);
    assign acc_end  = {2'b00, bus.i_addr[1:0]} + {1'b0, acc_size};
    assign acc_span = acc_end > 4'd4;

    always_comb begin
        acc_err = 1'b0;
        if (bus.i_funct3 inside {3'b011, 3'b110, 3'b111}) acc_err = 1'b1;
        if (bus.i_wren && bus.i_funct3[2])                 acc_err = 1'b1;
        if ({2'b00, bus.i_addr[31:2]} >= DEPTH)            acc_err = 1'b1;
        if (acc_span && (bus.i_addr[AW+1:2] == AW'(DEPTH - 1))) acc_err = 1'b1;
    end

    // Lane steering: 8-byte window spanning w0 (low half) and w0+1 (high half).
    always_comb begin
        case (size_of(f3_q))
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign be     = {4'b0000, size_mask} << off_q;
    assign wvec   = {32'h0, st_q} << {off_q, 3'b000};
    assign rd_src = (state == ACC1) ? {ram_rdata, word0_q} : {32'h0, ram_rdata};
    assign pair   = 32'(rd_src >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            LB:      ld_ext = {{24{pair[7]}}, pair[7:0]};
            LH:      ld_ext = {{16{pair[15]}}, pair[15:0]};
            LBU:     ld_ext = {24'h0, pair[7:0]};
            LHU:     ld_ext = {16'h0, pair[15:0]};
            default: ld_ext = pair;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = acc_err ? DONE : ACC0;
            ACC0: state_nx = span_q ? ACC1 : DONE;
            ACC1: state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    // In IDLE the RAM address follows the request so a load's first word is
    // read on the accepting edge; a spanning load reads w0+1 during ACC0.
    always_comb begin
        ready     = (state == IDLE) & i_reset;
        rvalid    = (state == DONE);
        ram_addr  = bus.i_addr[AW+1:2];
        ram_we    = '0;
        ram_wdata = wvec[31:0];
        unique case (state)
            ACC0: begin
                if (wren_q) begin
                    ram_addr = w0_q;
                    ram_we   = be[3:0];
                end else begin
                    ram_addr = w0_q + 1'b1;
                end
            end
            ACC1: begin
                ram_addr  = w0_q + 1'b1;
                ram_we    = wren_q ? be[7:4] : 4'b0000;
                ram_wdata = wvec[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wren_q  <= 1'b0;
            span_q  <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            w0_q    <= '0;
            st_q    <= '0;
            word0_q <= '0;
            ld_q    <= '0;
        end else begin
            if (accept) begin
                wren_q <= bus.i_wren;
                f3_q   <= bus.i_funct3;
                off_q  <= bus.i_addr[1:0];
                w0_q   <= bus.i_addr[AW+1:2];
                st_q   <= bus.i_st_data;
                span_q <= acc_span;
                err_q  <= acc_err;
                ld_q   <= '0;
            end
            if (state == ACC0) begin
                word0_q <= ram_rdata;
                if (!wren_q && !span_q) ld_q <= ld_ext;
            end
            if (state == ACC1 && !wren_q) ld_q <= ld_ext;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_rvalid  = rvalid;
    assign bus.o_ld_data = ld_q;
    assign bus.o_err     = err_q;

    dmem_bytelane_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk (i_clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the load/store path.
- Accepts one RV32I load or store request at a time over a ready/valid handshake and services it from a word-wide, byte-enable synchronous RAM.
- Handles misaligned accesses that straddle two words as two sequential RAM cycles.
- Returns sign- or zero-extended load data, or a store acknowledge, with an error flag.

Parameters:
- DEPTH, 512, number of 32-bit words in the RAM. Byte address space is 0 .. 4*DEPTH-1.
- AW, $clog2(DEPTH), word-index width; derived, do not override.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  request valid.
- o_ready  out  1  request accepted when i_req & o_ready are both high at a clock edge.
- i_wren  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I load/store funct3.
- i_addr  in  32  byte address; any alignment allowed.
- i_st_data  in  32  store data, right-aligned.
- o_rvalid  out  1  one-cycle response strobe.
- o_ld_data  out  32  load result; 0 for stores and errors.
- o_err  out  1  valid with o_rvalid; access rejected.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, o_rvalid=0, o_ld_data=0, o_err=0. o_ready forced 0 while i_reset=0. RAM contents are not reset.
- Reset asserted mid-operation aborts the access. A store already written stays written. No response is issued.
- o_ready = (state==IDLE) & i_reset. It is combinational from state; no request is accepted outside IDLE.
- Request latching:
  - On accept, latch wren, funct3, off=i_addr[1:0], w0=i_addr[AW+1:2], and store data.
  - Size: 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
  - span = (off+size > 4).
- Error on accept, if any of:
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1;
  - i_addr[31:2] >= DEPTH;
  - span and w0 == DEPTH-1 (no wrap-around).
  - On error go to DONE directly: no RAM write, o_err=1, o_ld_data=0.
- States:
  - IDLE -> ACC0 on accept with no error; IDLE -> DONE on accept with error.
  - ACC0: RAM op on word w0. Load: read issued at accept, data valid in ACC0. Store: write lanes be[3:0]. ACC0 -> ACC1 if span, else DONE.
  - ACC1: RAM op on word w0+1. Store writes lanes be[7:4]. ACC1 -> DONE.
  - DONE: o_rvalid=1 for exactly this cycle, with registered o_ld_data and o_err. DONE -> IDLE.
- Byte-lane rules:
  - 8-bit mask be = (size mask) << off.
  - 64-bit write vector = {32'b0, st_data} << (8*off). Low half goes to word w0, high half to w0+1.
  - Load: pair = {word1, word0} >> (8*off).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW takes pair[31:0].
- Latency, with accept in cycle 0:
  - non-spanning: o_rvalid in cycle 2;
  - spanning: o_rvalid in cycle 3.
  - Next accept is possible in the cycle after DONE.
- Store then load to the same address returns the new data. There is no read-during-write hazard because accesses are serialised.
- No simultaneous requests are possible; the handshake blocks them.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams LB/LH/LW/LBU/LHU/SB/SH/SW;
  - state enum {IDLE, ACC0, ACC1, DONE};
  - function size_of(funct3).
- Sub-module dmem_bytelane_ram: single-port, DEPTH x 32, 4 byte write enables, synchronous read (1-cycle), no reset.
- The FSM, lane shifting and extension stay in dmem_responder.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> ack rvalid cycle 2, err=0; load returns 0xDEADBEEF in cycle 2.
- LB @0x13 after the above -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE. LH @0x12 -> 0xFFFFDEAD.
- Spanning store then load:
  - SW 0x11223344 @0x23: bytes 0x44 @0x23, 0x33 @0x24, 0x22 @0x25, 0x11 @0x26.
  - o_ready low for 3 cycles; ack in cycle 3.
  - LW @0x23 -> 0x11223344 with rvalid in cycle 3; LW @0x24 -> 0x??112233 with 0x27 byte untouched.
- Errors (no writes occur; verify by readback):
  - LW @0x800 with DEPTH=512 -> err=1, data 0.
  - SH @0x7FF (span past top) -> err=1.
  - funct3=011 -> err=1.
  - SB funct3=100 -> err=1.
- Drop i_reset during ACC1 of a spanning store, then release:
  - no rvalid; o_ready=0 during reset and 1 after release;
  - word w0 holds new bytes, w0+1 holds old bytes.
- Back-to-back requests with i_req held high: accepts only in IDLE cycles. Five LW requests complete in 15 cycles; rvalid strobes one cycle each.
